dot_operand_loader: RTL

Upstream feeder for the 4-lane nibble dot-product / running-max stage. Accepts operand bytes over a valid/ready handshake, buffers them in a small FIFO and serializes each byte into two 4-bit beats, low nibble first, tagged as weight or input. It also tracks vector boundaries so the consumer knows when a full 4-nibble input vector has been shifted in.

---
 rtl/dot_operand_loader_pkg.sv | 27 ++
 rtl/dot_operand_loader_fifo.sv | 53 +++++
 rtl/dot_operand_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/dot_operand_loader_pkg.sv
// Shared definitions for the nibble dot-product operand path: widths,
// serializer states, lane encoding and a nibble-select helper.
package dot_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

  // Lane tag carried alongside every byte and beat.
  localparam logic LANE_WEIGHT = 1'b1;
  localparam logic LANE_INPUT  = 1'b0;

  // Byte serializer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EMIT_LO = 2'd1,
    EMIT_HI = 2'd2
  } ser_state_t;

  // Pick the low (hi = 0) or high (hi = 1) nibble of an operand byte.
  function automatic logic [NIBBLE_W-1:0] nibble_of(input logic [BYTE_W-1:0] b,
                                                     input logic              hi);
    logic [NIBBLE_W-1:0] n;
    n = hi ? b[BYTE_W-1:NIBBLE_W] : b[NIBBLE_W-1:0];
    return n;
  endfunction

endpackage

// File: rtl/dot_operand_loader_fifo.sv
// Small synchronous FIFO with first-word-fall-through head. Pointers carry
// one extra MSB so full and empty can be told apart when the indices match.
module dot_byte_fifo
  import dot_pkg::*;
#(
  parameter int WIDTH = BYTE_W + 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  // Writes into a full FIFO and reads from an empty one are ignored.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head = mem[rd_ptr[AW-1:0]];

  // Pointer update; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dot_operand_loader.sv
// Operand feeder for the 4-lane nibble dot-product stage. Buffers tagged
// bytes, then serializes each into two beats (low nibble first) and tracks
// per-lane nibble counts to flag completed input vectors and loaded weights.
module dot_operand_loader
  import dot_pkg::*;
#(
  parameter int FIFO_DEPTH      = 4,
  parameter int NIBBLES_PER_VEC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_weight,
  input  logic       hold,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_sel,
  output logic       vec_done,
  output logic       weights_loaded
);

  localparam int              ENTRY_W  = BYTE_W + 1;
  localparam int              CNT_W    = (NIBBLES_PER_VEC > 1) ? $clog2(NIBBLES_PER_VEC) : 1;
  localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES_PER_VEC - 1);

  ser_state_t          state_q;
  ser_state_t          state_d;

  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_head;

  logic [BYTE_W-1:0]   byte_reg;
  logic                tag_reg;

  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    w_cnt;
  logic                in_beat;
  logic                w_beat;

  // ---- Stage 0: byte acceptance into the FIFO ----
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  dot_byte_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({in_is_weight, in_data}),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // ---- Stage 1: serializer holding the byte currently being emitted ----

  // Serializer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and FIFO pop; EMIT_HI reloads directly so bytes stream without a bubble.
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !hold) begin
          fifo_pop = 1'b1;
          state_d  = EMIT_LO;
        end
      end
      EMIT_LO: begin
        if (!hold) state_d = EMIT_HI;
      end
      EMIT_HI: begin
        if (!hold) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = EMIT_LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane tag of the in-flight byte; cleared so a stale tag never survives reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           tag_reg <= LANE_INPUT;
    else if (fifo_pop) tag_reg <= fifo_head[ENTRY_W-1];
  end

  // Operand byte of the in-flight byte; only observed while in an EMIT state.
  always_ff @(posedge clk) begin
    if (fifo_pop) byte_reg <= fifo_head[BYTE_W-1:0];
  end

  // ---- Stage 2: beat decode from registered state and hold ----

  // Beat outputs; everything is forced to zero outside the EMIT states.
  always_comb begin
    out_valid  = 1'b0;
    out_nibble = '0;
    out_sel    = LANE_INPUT;
    case (state_q)
      EMIT_LO: begin
        out_valid  = !hold;
        out_nibble = nibble_of(byte_reg, 1'b0);
        out_sel    = tag_reg;
      end
      EMIT_HI: begin
        out_valid  = !hold;
        out_nibble = nibble_of(byte_reg, 1'b1);
        out_sel    = tag_reg;
      end
      default: begin
        out_valid  = 1'b0;
        out_nibble = '0;
        out_sel    = LANE_INPUT;
      end
    endcase
  end

  assign in_beat = out_valid && (out_sel == LANE_INPUT);
  assign w_beat  = out_valid && (out_sel == LANE_WEIGHT);

  // Per-lane nibble position; each counter moves only on its own lane's beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_cnt <= '0;
      w_cnt  <= '0;
    end else begin
      if (in_beat) in_cnt <= (in_cnt == LAST_NIB) ? '0 : in_cnt + CNT_W'(1);
      if (w_beat)  w_cnt  <= (w_cnt  == LAST_NIB) ? '0 : w_cnt  + CNT_W'(1);
    end
  end

  // Sticky flag raised once a full weight vector has been shifted out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           weights_loaded <= 1'b0;
    else if (w_beat && w_cnt == LAST_NIB) weights_loaded <= 1'b1;
  end

  assign vec_done = in_beat && (in_cnt == LAST_NIB);

endmodule
